// File: rtl/control_pago_if.sv
// Payment sequencer handshake bundle: menu, coin, card-bank, dispenser and printer signals.
// master = vending top / peripherals side, slave = control_pago.
interface control_pago_if #(
    parameter int unsigned PRICE_W = 8
);
    logic               start;
    logic [PRICE_W-1:0] price;
    logic               efe;
    logic               tar;
    logic               coin_v;
    logic [PRICE_W-1:0] coin_val;
    logic               cancel;
    logic               auth_req;
    logic               auth_ack;
    logic               auth_ok;
    logic               chg_rdy;
    logic               chg_pulse;
    logic               rec_req;
    logic               rec_done;
    logic               menu_en;
    logic               busy;
    logic [PRICE_W-1:0] credit;
    logic               paid;
    logic               fail;

    modport master (
        output start, price, efe, tar, coin_v, coin_val, cancel,
               auth_ack, auth_ok, chg_rdy, rec_done,
        input  auth_req, chg_pulse, rec_req, menu_en, busy, credit, paid, fail
    );

    modport slave (
        input  start, price, efe, tar, coin_v, coin_val, cancel,
               auth_ack, auth_ok, chg_rdy, rec_done,
        output auth_req, chg_pulse, rec_req, menu_en, busy, credit, paid, fail
    );
endinterface

// File: rtl/control_pago.sv
// Payment transaction sequencer: price latch, menu selection, cash/change/refund path,
// card authorisation with timeout, receipt handshake and a one-cycle paid/fail result.
module control_pago #(
    parameter int unsigned PRICE_W = 8,
    parameter int unsigned TIMEOUT = 200
) (
    input logic           clk,
    input logic           reset,
    control_pago_if.slave bus
);
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_WAIT_SEL = 4'd1;
    localparam logic [3:0] S_CASH     = 4'd2;
    localparam logic [3:0] S_CHANGE   = 4'd3;
    localparam logic [3:0] S_AUTH     = 4'd4;
    localparam logic [3:0] S_RECEIPT  = 4'd5;
    localparam logic [3:0] S_DONE     = 4'd6;
    localparam logic [3:0] S_REFUND   = 4'd7;
    localparam logic [3:0] S_ABORT    = 4'd8;

    logic [3:0]         state, state_nxt;
    logic [PRICE_W-1:0] prc, prc_nxt;
    logic [PRICE_W-1:0] rem, rem_nxt;
    logic [PRICE_W-1:0] credit_q, credit_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;

    logic [PRICE_W-1:0] coin_add;
    logic [PRICE_W:0]   sum;
    logic [PRICE_W-1:0] upd;
    logic               dispense;

    logic auth_req_q, rec_req_q, menu_en_q, busy_q, paid_q, fail_q;

    // Saturating credit update and dispenser strobe
    always_comb begin
        coin_add = bus.coin_v ? bus.coin_val : '0;
        sum      = {1'b0, credit_q} + {1'b0, coin_add};
        upd      = sum[PRICE_W] ? {PRICE_W{1'b1}} : sum[PRICE_W-1:0];
        dispense = ((state == S_CHANGE) || (state == S_REFUND)) && bus.chg_rdy && (rem != '0);
    end

    // Next-state and datapath decisions
    always_comb begin
        state_nxt  = state;
        prc_nxt    = prc;
        rem_nxt    = rem;
        credit_nxt = credit_q;
        cnt_nxt    = cnt;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    prc_nxt    = bus.price;
                    credit_nxt = '0;
                    state_nxt  = S_WAIT_SEL;
                end
            end
            S_WAIT_SEL: begin
                if (bus.cancel) begin
                    state_nxt = S_ABORT;
                end else if (bus.efe) begin
                    state_nxt = S_CASH;
                end else if (bus.tar) begin
                    cnt_nxt   = '0;
                    state_nxt = S_AUTH;
                end
            end
            S_CASH: begin
                credit_nxt = upd;
                if (bus.cancel) begin
                    rem_nxt   = upd;
                    state_nxt = S_REFUND;
                end else if (upd >= prc) begin
                    rem_nxt   = upd - prc;
                    state_nxt = S_CHANGE;
                end
            end
            S_CHANGE, S_REFUND: begin
                if (rem == '0) begin
                    state_nxt = (state == S_CHANGE) ? S_RECEIPT : S_ABORT;
                end else if (dispense) begin
                    rem_nxt = rem - PRICE_W'(1);
                end
            end
            S_AUTH: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (bus.cancel) begin
                    state_nxt = S_ABORT;
                end else if (bus.auth_ack) begin
                    state_nxt = bus.auth_ok ? S_RECEIPT : S_ABORT;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_ABORT;
                end
            end
            S_RECEIPT: begin
                if (bus.rec_done) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE, S_ABORT: begin
                credit_nxt = '0;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, datapath and output registers; outputs follow the state being entered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            prc        <= '0;
            rem        <= '0;
            credit_q   <= '0;
            cnt        <= '0;
            auth_req_q <= 1'b0;
            rec_req_q  <= 1'b0;
            menu_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            paid_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            prc        <= prc_nxt;
            rem        <= rem_nxt;
            credit_q   <= credit_nxt;
            cnt        <= cnt_nxt;
            auth_req_q <= (state_nxt == S_AUTH);
            rec_req_q  <= (state_nxt == S_RECEIPT);
            menu_en_q  <= (state_nxt == S_WAIT_SEL);
            busy_q     <= (state_nxt != S_IDLE);
            paid_q     <= (state_nxt == S_DONE);
            fail_q     <= (state_nxt == S_ABORT);
        end
    end

    assign bus.chg_pulse = dispense;
    assign bus.auth_req  = auth_req_q;
    assign bus.rec_req   = rec_req_q;
    assign bus.menu_en   = menu_en_q;
    assign bus.busy      = busy_q;
    assign bus.credit    = credit_q;
    assign bus.paid      = paid_q;
    assign bus.fail      = fail_q;
endmodule

// File: tb/tb_control_pago.sv
// Bench for control_pago: transaction-level reference model compared every cycle,
// plus directed scenarios with hand-computed pulse counts and values.
module tb_control_pago;
    localparam int unsigned PRICE_W = 8;
    localparam int unsigned TIMEOUT = 200;
    localparam int          CMAX    = 255;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    control_pago_if #(.PRICE_W(PRICE_W)) bus ();
    control_pago #(.PRICE_W(PRICE_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a transaction in one of a few phases
    typedef enum int {M_IDLE, M_SEL, M_CASH, M_PAYOUT, M_CARD, M_PRINT, M_OK, M_KO} mode_t;
    mode_t mode;
    int    m_price, m_credit, m_rem, m_wait;
    bit    m_refund;
    int    cash_after;

    always_comb begin
        cash_after = m_credit + (bus.coin_v ? int'(bus.coin_val) : 0);
        if (cash_after > CMAX) cash_after = CMAX;
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode <= M_IDLE; m_price <= 0; m_credit <= 0; m_rem <= 0; m_wait <= 0; m_refund <= 1'b0;
        end else if (mode == M_IDLE) begin
            if (bus.start) begin
                m_price <= int'(bus.price); m_credit <= 0; mode <= M_SEL;
            end
        end else if (mode == M_SEL) begin
            if (bus.cancel) mode <= M_KO;
            else if (bus.efe) mode <= M_CASH;
            else if (bus.tar) begin mode <= M_CARD; m_wait <= 0; end
        end else if (mode == M_CASH) begin
            m_credit <= cash_after;
            if (bus.cancel) begin
                m_rem <= cash_after; m_refund <= 1'b1; mode <= M_PAYOUT;
            end else if (cash_after >= m_price) begin
                m_rem <= cash_after - m_price; m_refund <= 1'b0; mode <= M_PAYOUT;
            end
        end else if (mode == M_PAYOUT) begin
            if (m_rem == 0) mode <= m_refund ? M_KO : M_PRINT;
            else if (bus.chg_rdy) m_rem <= m_rem - 1;
        end else if (mode == M_CARD) begin
            m_wait <= m_wait + 1;
            if (bus.cancel) mode <= M_KO;
            else if (bus.auth_ack) mode <= bus.auth_ok ? M_PRINT : M_KO;
            else if (m_wait + 1 >= int'(TIMEOUT)) mode <= M_KO;
        end else if (mode == M_PRINT) begin
            if (bus.rec_done) mode <= M_OK;
        end else begin
            m_credit <= 0; mode <= M_IDLE;
        end
    end

    // Per-cycle comparison and event counters, mid-cycle
    int n_pulse, n_paid, n_fail, n_auth, n_rec;
    always @(negedge clk) begin
        chk("menu_en",   int'(bus.menu_en),   int'(mode == M_SEL));
        chk("busy",      int'(bus.busy),      int'(mode != M_IDLE));
        chk("auth_req",  int'(bus.auth_req),  int'(mode == M_CARD));
        chk("rec_req",   int'(bus.rec_req),   int'(mode == M_PRINT));
        chk("paid",      int'(bus.paid),      int'(mode == M_OK));
        chk("fail",      int'(bus.fail),      int'(mode == M_KO));
        chk("credit",    int'(bus.credit),    m_credit);
        chk("chg_pulse", int'(bus.chg_pulse), int'(mode == M_PAYOUT && bus.chg_rdy && m_rem > 0));
        n_pulse += int'(bus.chg_pulse);
        n_paid  += int'(bus.paid);
        n_fail  += int'(bus.fail);
        n_auth  += int'(bus.auth_req);
        n_rec   += int'(bus.rec_req);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_counts();
        n_pulse = 0; n_paid = 0; n_fail = 0; n_auth = 0; n_rec = 0;
    endtask

    task automatic do_start(input int p);
        bus.start = 1'b1; bus.price = PRICE_W'(p);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic sel(input bit e, input bit t);
        bus.efe = e; bus.tar = t;
        tick();
        bus.efe = 1'b0; bus.tar = 1'b0;
    endtask

    task automatic coin(input int v);
        bus.coin_v = 1'b1; bus.coin_val = PRICE_W'(v);
        tick();
        bus.coin_v = 1'b0; bus.coin_val = '0;
    endtask

    // Run until idle; printer answers at once, dispenser optionally stalls 1,0,1,1
    task automatic wait_idle(input int budget, input bit stall, input string name);
        bit pat [4];
        int n;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1;
        n = 0;
        while (bus.busy && n < budget) begin
            bus.chg_rdy  = stall ? pat[n % 4] : 1'b1;
            bus.rec_done = bus.rec_req;
            tick();
            n++;
        end
        bus.chg_rdy = 1'b0; bus.rec_done = 1'b0;
        if (bus.busy) chk({name, " idle timeout"}, 1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 0; bus.price = '0; bus.efe = 0; bus.tar = 0; bus.coin_v = 0; bus.coin_val = '0;
        bus.cancel = 0; bus.auth_ack = 0; bus.auth_ok = 0; bus.chg_rdy = 0; bus.rec_done = 0;
        clr_counts();
        repeat (3) tick();
        chk("reset busy", int'(bus.busy), 0);
        chk("reset credit", int'(bus.credit), 0);
        chk("reset menu_en", int'(bus.menu_en), 0);
        reset = 1'b1;
        tick();

        // Cash, exact payment
        clr_counts();
        do_start(50);
        chk("start->menu_en", int'(bus.menu_en), 1);
        sel(1'b1, 1'b0);
        coin(20); chk("credit step1", int'(bus.credit), 20);
        coin(20); chk("credit step2", int'(bus.credit), 40);
        coin(10); chk("credit step3", int'(bus.credit), 50);
        wait_idle(50, 1'b0, "exact");
        chk("exact pulses", n_pulse, 0);
        chk("exact paid", n_paid, 1);

        // Cash with change, stalling dispenser
        clr_counts();
        do_start(35); sel(1'b1, 1'b0);
        coin(20); coin(25);
        chk("change credit", int'(bus.credit), 45);
        wait_idle(100, 1'b1, "change");
        chk("change pulses", n_pulse, 10);
        chk("change paid", n_paid, 1);

        // Cancel with simultaneous coin
        clr_counts();
        do_start(100); sel(1'b1, 1'b0);
        coin(30);
        bus.cancel = 1'b1; bus.coin_v = 1'b1; bus.coin_val = 8'd10;
        tick();
        bus.cancel = 1'b0; bus.coin_v = 1'b0; bus.coin_val = '0;
        chk("cancel credit", int'(bus.credit), 40);
        wait_idle(100, 1'b0, "refund");
        chk("refund pulses", n_pulse, 40);
        chk("refund fail", n_fail, 1);
        chk("refund paid", n_paid, 0);

        // Card approved, ack on AUTH cycle 5
        clr_counts();
        do_start(10); sel(1'b0, 1'b1);
        repeat (4) tick();
        bus.auth_ack = 1'b1; bus.auth_ok = 1'b1;
        tick();
        bus.auth_ack = 1'b0; bus.auth_ok = 1'b0;
        chk("card rec_req", int'(bus.rec_req), 1);
        wait_idle(50, 1'b0, "card ok");
        chk("card ok auth cycles", n_auth, 5);
        chk("card ok paid", n_paid, 1);

        // Card declined
        clr_counts();
        do_start(10); sel(1'b0, 1'b1);
        repeat (4) tick();
        bus.auth_ack = 1'b1; bus.auth_ok = 1'b0;
        tick();
        bus.auth_ack = 1'b0;
        wait_idle(50, 1'b0, "card nok");
        chk("declined fail", n_fail, 1);
        chk("declined rec_req", n_rec, 0);
        chk("declined paid", n_paid, 0);

        // Card timeout without ack
        clr_counts();
        do_start(10); sel(1'b0, 1'b1);
        wait_idle(400, 1'b0, "timeout");
        chk("timeout auth cycles", n_auth, 200);
        chk("timeout fail", n_fail, 1);

        // Ack on the 200th cycle still succeeds
        clr_counts();
        do_start(10); sel(1'b0, 1'b1);
        repeat (199) tick();
        bus.auth_ack = 1'b1; bus.auth_ok = 1'b1;
        tick();
        bus.auth_ack = 1'b0; bus.auth_ok = 1'b0;
        chk("late ack rec_req", int'(bus.rec_req), 1);
        wait_idle(50, 1'b0, "late ack");
        chk("late ack auth cycles", n_auth, 200);
        chk("late ack paid", n_paid, 1);

        // Zero price and credit saturation
        clr_counts();
        do_start(0); sel(1'b1, 1'b0);
        wait_idle(50, 1'b0, "zero price");
        chk("zero price paid", n_paid, 1);
        clr_counts();
        do_start(255); sel(1'b1, 1'b0);
        coin(200); coin(100);
        chk("saturated credit", int'(bus.credit), 255);
        wait_idle(50, 1'b0, "saturate");
        chk("saturate pulses", n_pulse, 0);
        chk("saturate paid", n_paid, 1);

        // Reset in CHANGE with 7 units pending
        clr_counts();
        do_start(3); sel(1'b1, 1'b0);
        coin(10);
        tick();
        bus.chg_rdy = 1'b1;
        #2;
        chk("pre-reset chg_pulse", int'(bus.chg_pulse), 1);
        reset = 1'b0;
        #1;
        chk("async chg_pulse", int'(bus.chg_pulse), 0);
        chk("async busy", int'(bus.busy), 0);
        chk("async credit", int'(bus.credit), 0);
        bus.chg_rdy = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("reset no fail", n_fail, 0);
        do_start(20); sel(1'b1, 1'b1);
        chk("both sel auth_req", int'(bus.auth_req), 0);
        coin(5);
        chk("both sel credit", int'(bus.credit), 5);
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        wait_idle(50, 1'b0, "post reset");
        chk("post reset pulses", n_pulse, 5);
        chk("post reset fail", n_fail, 1);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
